accum_count_table: RTL and testbench

//   Receive end of the accum_addr/accum_din/accum_we write stream produced by the KVS search/update front end.

---
 rtl/wordcount_pkg.sv | 22 ++
 rtl/accum_table_ram.sv | 28 ++
 rtl/accum_count_table.sv | 240 ++++++++++++++++++++++++
 tb/tb_accum_count_table.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordcount_pkg.sv
// Shared definitions for the KVS word-count path: default table geometry,
// accumulator FSM states and accum_din field layout. Used by the search
// front end and by accum_count_table.
package wordcount_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 32;

  // accum_din = {key value, increment}
  localparam int VAL_LSB = 32;
  localparam int VAL_W   = 32;
  localparam int INC_LSB = 0;
  localparam int INC_W   = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } state_e;

endpackage

// File: rtl/accum_table_ram.sv
// Simple dual-port table storage: one write port and one registered read
// port with read enable. A read and a write to the same address on the same
// edge returns the old contents; the read data register holds while re_i=0.
//   clk      clock
//   we_i     write enable, waddr_i / wdata_i write address / data
//   re_i     read enable, raddr_i read address
//   rdata_o  registered read data
module accum_table_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/accum_count_table.sv
// Word-count accumulator table. Holds one {value, count} entry per KVS
// entry address, adds each incoming increment to the addressed count with a
// 2-stage read-modify-write, and on dump_kick streams all non-zero entries
// out through a valid/ready port.
//   clk, reset_n          clock, asynchronous active-low reset
//   ready                 table cleared, writes accepted (IDLE)
//   accum_addr/din/we     update stream (no backpressure)
//   dump_kick             start a dump (IDLE only); clear_on_dump sampled with it
//   busy, dump_done       activity flag, end-of-dump pulse
//   dout_addr/value/count/valid, dout_ready   dump output port
//   err_drop, err_sat     sticky error flags
module accum_count_table
  import wordcount_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ready,
  input  logic [31:0]       accum_addr,
  input  logic [63:0]       accum_din,
  input  logic              accum_we,
  input  logic              dump_kick,
  input  logic              clear_on_dump,
  output logic              busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [31:0]       dout_value,
  output logic [CNT_W-1:0]  dout_count,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err_drop,
  output logic              err_sat
);

  localparam int ENT_W = VAL_W + CNT_W;

  // Returns {carry, result}; result is all-ones when the add overflows.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    if (s[CNT_W]) sat_add = {1'b1, {CNT_W{1'b1}}};
    else          sat_add = s;
  endfunction

  state_e state_q, state_d;

  logic [ADDR_W-1:0] clr_idx_q;
  logic              drain_q;
  logic              clr_dump_q;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [VAL_W-1:0]  val_p1;
  logic [INC_W-1:0]  inc_p1;

  logic              fwd_vld_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [CNT_W-1:0]  fwd_cnt_q;

  logic [ADDR_W:0]   sw_idx_q;
  logic              dvld_p1;
  logic [ADDR_W-1:0] didx_p1;

  logic              dout_valid_q;
  logic [ADDR_W-1:0] dout_addr_q;
  logic [VAL_W-1:0]  dout_value_q;
  logic [CNT_W-1:0]  dout_count_q;

  logic ready_q, busy_q, dump_done_q, err_drop_q, err_sat_q;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [ENT_W-1:0]  ram_wdata, ram_rdata;

  logic              in_range, accept, drop;
  logic [CNT_W-1:0]  rd_cnt, base_cnt, sum_p1;
  logic [VAL_W-1:0]  rd_val;
  logic [CNT_W:0]    add_res;
  logic              carry_p1;
  logic              out_free, sw_more, sw_issue, dump_fin;

  accum_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Stage p0: accept the write and issue the RAM read
  assign in_range = (accum_addr[31:ADDR_W] == '0);
  assign accept   = accum_we && in_range && (state_q == IDLE);
  assign drop     = accum_we && !accept;

  // Stage p1: add increment; a write one cycle ahead to the same index has
  // not reached the RAM read in time, so its sum is taken from fwd_*.
  assign rd_cnt   = ram_rdata[CNT_W-1:0];
  assign rd_val   = ram_rdata[ENT_W-1:CNT_W];
  assign base_cnt = (fwd_vld_q && (fwd_addr_q == addr_p1)) ? fwd_cnt_q : rd_cnt;
  assign add_res  = sat_add(base_cnt, inc_p1);
  assign carry_p1 = add_res[CNT_W];
  assign sum_p1   = add_res[CNT_W-1:0];

  // Dump sweep: a new read is issued only when the entry already read can
  // move into the output register, so the RAM read register doubles as the
  // stall buffer.
  assign out_free = !dout_valid_q || dout_ready;
  assign sw_more  = !sw_idx_q[ADDR_W];
  assign sw_issue = (state_q == DUMP) && out_free && sw_more;
  assign dump_fin = (state_q == DUMP) && out_free && !sw_more && !dvld_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_idx_q == '1) state_d = IDLE;
      IDLE:  if (dump_kick)       state_d = DRAIN;
      DRAIN: if (drain_q)         state_d = DUMP;
      DUMP:  if (dump_fin)        state_d = IDLE;
      default:                    state_d = CLEAR;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_p1;
    ram_wdata = {val_p1, sum_p1};
    ram_re    = 1'b0;
    ram_raddr = accum_addr[ADDR_W-1:0];
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q;
        ram_wdata = '0;
      end
      IDLE, DRAIN: begin
        ram_we = vld_p1;
        ram_re = accept;
      end
      DUMP: begin
        ram_we    = clr_dump_q && dout_valid_q && dout_ready;
        ram_waddr = dout_addr_q;
        ram_wdata = '0;
        ram_re    = sw_issue;
        ram_raddr = sw_idx_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_idx_q    <= '0;
      drain_q      <= 1'b0;
      clr_dump_q   <= 1'b0;
      vld_p1       <= 1'b0;
      fwd_vld_q    <= 1'b0;
      sw_idx_q     <= '0;
      dvld_p1      <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_addr_q  <= '0;
      dout_value_q <= '0;
      dout_count_q <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      dump_done_q  <= 1'b0;
      err_drop_q   <= 1'b0;
      err_sat_q    <= 1'b0;
    end else begin
      if (state_q == CLEAR) clr_idx_q <= clr_idx_q + 1'b1;
      drain_q <= (state_q == DRAIN);
      if ((state_q == IDLE) && dump_kick) clr_dump_q <= clear_on_dump;
      vld_p1    <= accept;
      fwd_vld_q <= vld_p1;

      if (state_q == DRAIN) begin
        sw_idx_q     <= '0;
        dvld_p1      <= 1'b0;
        dout_valid_q <= 1'b0;
      end else if (state_q == DUMP) begin
        if (sw_issue) sw_idx_q <= sw_idx_q + 1'b1;
        if (out_free) begin
          dvld_p1 <= sw_issue;
          if (dvld_p1 && (rd_cnt != '0)) begin
            dout_valid_q <= 1'b1;
            dout_addr_q  <= didx_p1;
            dout_value_q <= rd_val;
            dout_count_q <= rd_cnt;
          end else begin
            dout_valid_q <= 1'b0;
          end
        end
      end else begin
        dout_valid_q <= 1'b0;
      end

      // Registered from state_d so they line up with state_q after reset
      // release while still reading 0 during reset.
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      dump_done_q <= dump_fin;
      if (drop)                err_drop_q <= 1'b1;
      if (vld_p1 && carry_p1)  err_sat_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= accum_addr[ADDR_W-1:0];
      val_p1  <= accum_din[VAL_LSB +: VAL_W];
      inc_p1  <= accum_din[INC_LSB +: INC_W];
    end
    fwd_addr_q <= addr_p1;
    fwd_cnt_q  <= sum_p1;
    if (sw_issue) didx_p1 <= sw_idx_q[ADDR_W-1:0];
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign dump_done  = dump_done_q;
  assign dout_valid = dout_valid_q;
  assign dout_addr  = dout_addr_q;
  assign dout_value = dout_value_q;
  assign dout_count = dout_count_q;
  assign err_drop   = err_drop_q;
  assign err_sat    = err_sat_q;

endmodule

// File: tb/tb_accum_count_table.sv
module tb_accum_count_table;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 2**ADDR_W;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic              clk;
  logic              reset_n;
  logic              ready;
  logic [31:0]       accum_addr;
  logic [63:0]       accum_din;
  logic              accum_we;
  logic              dump_kick;
  logic              clear_on_dump;
  logic              busy;
  logic              dump_done;
  logic [ADDR_W-1:0] dout_addr;
  logic [31:0]       dout_value;
  logic [CNT_W-1:0]  dout_count;
  logic              dout_valid;
  logic              dout_ready;
  logic              err_drop;
  logic              err_sat;

  accum_count_table #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ready         (ready),
    .accum_addr    (accum_addr),
    .accum_din     (accum_din),
    .accum_we      (accum_we),
    .dump_kick     (dump_kick),
    .clear_on_dump (clear_on_dump),
    .busy          (busy),
    .dump_done     (dump_done),
    .dout_addr     (dout_addr),
    .dout_value    (dout_value),
    .dout_count    (dout_count),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .err_drop      (err_drop),
    .err_sat       (err_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: plain per-index count/value with saturating add.
  longint unsigned m_cnt [DEPTH];
  logic [31:0]     m_val [DEPTH];
  bit              m_sat, m_drop;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_cnt[i] = 0;
      m_val[i] = '0;
    end
  endtask

  function automatic logic [127:0] out_vec();
    return {ready, busy, dump_done, dout_valid, dout_addr, dout_value, dout_count, err_drop, err_sat};
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] val, input logic [31:0] inc);
    accum_we   = 1'b1;
    accum_addr = addr;
    accum_din  = {val, inc};
    @(negedge clk);
    if (addr < DEPTH) begin
      m_cnt[addr] = m_cnt[addr] + inc;
      if (m_cnt[addr] > CMAX) begin
        m_cnt[addr] = CMAX;
        m_sat = 1'b1;
      end
      m_val[addr] = val;
    end else begin
      m_drop = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    accum_we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called with n0 negedges already elapsed since reset release.
  task automatic wait_ready(input string tag, input int n0);
    int n;
    n = n0;
    while (!ready && n < DEPTH + 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_clear_len"}, (n >= DEPTH && n <= DEPTH + 2), 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic dump(input string tag, input bit clr, input bit rand_rdy, input bit inject);
    int unsigned     e_addr [$];
    logic [31:0]     e_val  [$];
    longint unsigned e_cnt  [$];
    logic [127:0]    got    [$];
    logic [127:0]    prev;
    bit              stalled, done;
    int              n, lim;

    for (int i = 0; i < DEPTH; i++)
      if (m_cnt[i] != 0) begin
        e_addr.push_back(i);
        e_val.push_back(m_val[i]);
        e_cnt.push_back(m_cnt[i]);
      end

    dump_kick     = 1'b1;
    clear_on_dump = clr;
    @(negedge clk);
    dump_kick     = 1'b0;
    clear_on_dump = 1'b0;
    stalled = 1'b0;
    done    = 1'b0;
    prev    = '0;
    n       = 0;
    while (!done && n < 4 * DEPTH) begin
      if (stalled)
        check({tag, "_hold"}, {dout_valid, dout_addr, dout_value, dout_count}, prev);
      if (dump_done) begin
        done     = 1'b1;
        accum_we = 1'b0;
      end else begin
        dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dout_valid && dout_ready)
          got.push_back({dout_addr, dout_value, dout_count});
        stalled = dout_valid && !dout_ready;
        prev    = {dout_valid, dout_addr, dout_value, dout_count};
        if (inject) begin
          accum_we   = 1'b1;
          accum_addr = $urandom_range(0, DEPTH - 1);
          accum_din  = {$urandom, 32'd1};
          m_drop     = 1'b1;
        end
        @(negedge clk);
        n++;
      end
    end
    accum_we   = 1'b0;
    dout_ready = 1'b1;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_idle_after"}, {busy, ready, dout_valid}, 3'b010);
    if (!rand_rdy) check({tag, "_latency"}, (n <= DEPTH + 8), 1'b1);
    check({tag, "_nbeats"}, got.size(), e_addr.size());
    lim = (got.size() < e_addr.size()) ? got.size() : e_addr.size();
    for (int i = 0; i < lim; i++)
      check({tag, "_beat"}, got[i], {ADDR_W'(e_addr[i]), e_val[i], CNT_W'(e_cnt[i])});
    if (clr) model_clear();
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    accum_addr    = '0;
    accum_din     = '0;
    accum_we      = 1'b0;
    dump_kick     = 1'b0;
    clear_on_dump = 1'b0;
    dout_ready    = 1'b1;
    m_sat         = 1'b0;
    m_drop        = 1'b0;
    model_clear();

    // 1: reset state, clear sweep, empty dump
    repeat (3) @(negedge clk);
    check("rst_outputs", out_vec(), '0);
    reset_n = 1'b1;
    wait_ready("t1", 0);
    dump("t1_empty", 1'b0, 1'b0, 1'b0);

    // 2: back-to-back same-address writes, then another index
    wr(32'd5, 32'hAAAA_0001, 32'd1);
    wr(32'd5, 32'hAAAA_0001, 32'd1);
    wr(32'd5, 32'hAAAA_0001, 32'd1);
    wr(32'd9, 32'hBBBB_0002, 32'd4);
    idle(3);
    dump("t2", 1'b0, 1'b0, 1'b0);

    // 3: same contents with a random sink
    dump("t3_rand", 1'b0, 1'b1, 1'b0);

    // 4: saturation
    wr(32'd20, 32'hC0DE_0004, 32'hFFFF_FFFE);
    idle(3);
    check("t4_sat_before", err_sat, 1'b0);
    wr(32'd20, 32'hC0DE_0005, 32'd3);
    idle(3);
    check("t4_sat_after", err_sat, m_sat);

    // 5: dropped writes
    check("t5_drop_before", err_drop, 1'b0);
    wr(32'h0000_0400, 32'h1111_1111, 32'd7);
    idle(3);
    check("t5_drop_range", err_drop, m_drop);
    dump("t5_inject", 1'b0, 1'b1, 1'b1);
    check("t5_drop_sticky", err_drop, 1'b1);

    // random update mix, then dump against the model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else wr(($urandom_range(0, 8) == 8) ? DEPTH - 1 : $urandom_range(0, 7),
              $urandom,
              ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1000));
    end
    idle(3);
    check("rand_sat", err_sat, m_sat);
    dump("rand", 1'b0, 1'b1, 1'b0);

    // 6: clear-on-dump, then reset mid-dump
    dump("t6_clr", 1'b1, 1'b1, 1'b0);
    dump("t6_after", 1'b0, 1'b0, 1'b0);
    wr(32'd3, 32'h3333_0000, 32'd2);
    wr(32'd100, 32'h6464_0000, 32'd5);
    idle(3);
    dump_kick = 1'b1;
    @(negedge clk);
    dump_kick = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_outputs", out_vec(), '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_clear_rerun", {busy, ready}, 2'b10);
    wait_ready("t6", 1);
    m_sat  = 1'b0;
    m_drop = 1'b0;
    model_clear();
    check("t6_err_cleared", {err_drop, err_sat}, {m_drop, m_sat});
    dump("t6_post_reset", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
